// File: rtl/rr_arbiter.sv
// rr_arbiter: four-way round-robin arbiter with a registered 2-to-4 decoder
// interface ({A,B} index plus E enable), a mandatory one-cycle gap between
// owners, and an optional grant-length timeout that reports revocation on tmo.
module rr_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic       A,
  output logic       B,
  output logic       E,
  output logic       tmo
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] ptr_q, ptr_d;
  logic       e_q, e_d;
  logic       tmo_q, tmo_d;
  logic [7:0] timer_q, timer_d;

  logic [1:0] winner;
  logic       timer_hit;
  logic       owner_req;

  // Rotating priority search: scan ptr+4 down to ptr+1 so the nearest
  // requester after the last owner is the final (winning) assignment.
  always_comb begin
    logic [1:0] cand;
    winner = ptr_q;
    cand   = ptr_q;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr_q + 2'(k);
      if (req[cand]) begin
        winner = cand;
      end
    end
  end

  // The timer counts completed GRANT cycles, so the limit is reached on the
  // edge that closes the TIMEOUT-th cycle; zero disables the limit entirely.
  always_comb begin
    timer_hit = (TIMEOUT != 0) && ((32'(timer_q) + 32'd1) == TIMEOUT);
    owner_req = req[idx_q];
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so every port comes straight from a flop.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    e_d     = 1'b0;
    tmo_d   = 1'b0;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          idx_d   = winner;
          e_d     = 1'b1;
          timer_d = 8'd0;
        end
      end
      GRANT: begin
        timer_d = timer_q + 8'd1;
        if (done || !owner_req || timer_hit) begin
          state_d = GAP;
          ptr_d   = idx_q;
          tmo_d   = timer_hit && !done && owner_req;
        end else begin
          e_d = 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset parks the pointer at 3 so the first
  // search after reset starts from requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      ptr_q   <= 2'd3;
      e_q     <= 1'b0;
      tmo_q   <= 1'b0;
      timer_q <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      e_q     <= e_d;
      tmo_q   <= tmo_d;
      timer_q <= timer_d;
    end
  end

  assign A   = idx_q[1];
  assign B   = idx_q[0];
  assign E   = e_q;
  assign tmo = tmo_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: drives two arbiters (TIMEOUT=16 and TIMEOUT=0) from the same
// inputs and checks both every cycle against a behavioural owner/phase model,
// plus directed scenarios with hand-computed literal expectations.
module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic       a0, b0, e0, t0;
  logic       a1, b1, e1, t1;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  // Model state per DUT: phase 0=idle 1=granted 2=gap
  int mPhase[2];
  int mIdx[2];
  int mLast[2];
  int mLen[2];
  bit mTmo[2];

  rr_arbiter #(.TIMEOUT(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .A(a0), .B(b0), .E(e0), .tmo(t0)
  );

  rr_arbiter #(.TIMEOUT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .A(a1), .B(b1), .E(e1), .tmo(t1)
  );

  // free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  function automatic int modelLimit(input int m);
    return (m == 0) ? 16 : 0;
  endfunction

  // Behavioural model: who owns the bus, how long they have held it, and
  // whether we are in the mandatory quiet cycle after a release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        mPhase[m] = 0;
        mIdx[m]   = 0;
        mLast[m]  = 3;
        mLen[m]   = 0;
        mTmo[m]   = 1'b0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        mTmo[m] = 1'b0;
        if (mPhase[m] == 1) begin
          mLen[m] = mLen[m] + 1;
          if (done || !req[mIdx[m]] ||
              (modelLimit(m) != 0 && mLen[m] == modelLimit(m))) begin
            mTmo[m]   = !done && req[mIdx[m]];
            mLast[m]  = mIdx[m];
            mPhase[m] = 2;
          end
        end else if (mPhase[m] == 2) begin
          mPhase[m] = 0;
        end else if (req != 4'b0000) begin
          bit found;
          found = 1'b0;
          for (int k = 1; k <= 4; k++) begin
            if (!found && req[(mLast[m] + k) % 4]) begin
              mIdx[m] = (mLast[m] + k) % 4;
              found   = 1'b1;
            end
          end
          mPhase[m] = 1;
          mLen[m]   = 0;
        end
      end
    end
  end

  task automatic compareDut(input int m, input logic e, input logic [1:0] ab, input logic t);
    logic       expE;
    logic [1:0] expAb;
    expE  = (mPhase[m] == 1);
    expAb = 2'(mIdx[m]);
    checks++;
    if (e !== expE || ab !== expAb || t !== mTmo[m]) begin
      errors++;
      $display("[TB] FAIL model_dut%0d t=%0t got E=%b AB=%b tmo=%b expected E=%b AB=%b tmo=%b",
               m, $time, e, ab, t, expE, expAb, mTmo[m]);
    end
  endtask

  // Every-cycle comparison of both DUTs against the model, away from posedge
  always @(negedge clk) begin
    if (checkEn && rst_n) begin
      compareDut(0, e0, {a0, b0}, t0);
      compareDut(1, e1, {a1, b1}, t1);
    end
  end

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
  endtask

  task automatic checkOutput(input string name, input logic expE, input logic [1:0] expAb,
                             input logic expTmo);
    checks++;
    if (e0 !== expE || {a0, b0} !== expAb || t0 !== expTmo) begin
      errors++;
      $display("[TB] FAIL %s t=%0t got E=%b AB=%b tmo=%b expected E=%b AB=%b tmo=%b",
               name, $time, e0, {a0, b0}, t0, expE, expAb, expTmo);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulseReset();
    #2 rst_n = 1'b0;
    nextCycle();
    rst_n = 1'b1;
  endtask

  // Directed scenarios followed by randomized traffic
  initial begin
    logic [1:0] rot[5];
    int eHigh;
    int tmoCnt;
    rot[0] = 2'd0; rot[1] = 2'd1; rot[2] = 2'd2; rot[3] = 2'd3; rot[4] = 2'd0;

    #1 rst_n = 1'b0;
    #2 checkOutput("reset_state", 1'b0, 2'b00, 1'b0);
    nextCycle();
    rst_n   = 1'b1;
    checkEn = 1'b1;

    $display("[TB] rotation with all four requesting");
    applyStimulus(4'b1111, 1'b0);
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      checkOutput("rot_grant", 1'b1, rot[i], 1'b0);
      applyStimulus(4'b1111, 1'b1);
      nextCycle();
      checkOutput("rot_gap", 1'b0, rot[i], 1'b0);
      applyStimulus(4'b1111, 1'b0);
      nextCycle();
      checkOutput("rot_idle", 1'b0, rot[i], 1'b0);
    end
    applyStimulus(4'b0000, 1'b0);

    $display("[TB] timeout on sole requester 2");
    applyStimulus(4'b0100, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      nextCycle();
      checkOutput("tmo_hold", 1'b1, 2'd2, 1'b0);
    end
    nextCycle();
    checkOutput("tmo_pulse", 1'b0, 2'd2, 1'b1);
    applyStimulus(4'b0000, 1'b0);
    nextCycle();
    checkOutput("tmo_after", 1'b0, 2'd2, 1'b0);

    $display("[TB] done coinciding with timeout");
    applyStimulus(4'b0100, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      nextCycle();
      checkOutput("tmo_done_hold", 1'b1, 2'd2, 1'b0);
      if (i == 16) applyStimulus(4'b0100, 1'b1);
    end
    nextCycle();
    checkOutput("tmo_suppressed", 1'b0, 2'd2, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    nextCycle();
    checkOutput("tmo_suppressed_idle", 1'b0, 2'd2, 1'b0);

    $display("[TB] owner drops request");
    pulseReset();
    applyStimulus(4'b1010, 1'b0);
    nextCycle();
    checkOutput("drop_grant1", 1'b1, 2'd1, 1'b0);
    nextCycle();
    checkOutput("drop_grant1_hold", 1'b1, 2'd1, 1'b0);
    applyStimulus(4'b1000, 1'b0);
    nextCycle();
    checkOutput("drop_gap", 1'b0, 2'd1, 1'b0);
    nextCycle();
    checkOutput("drop_idle", 1'b0, 2'd1, 1'b0);
    nextCycle();
    checkOutput("drop_grant3", 1'b1, 2'd3, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    nextCycle();
    nextCycle();

    $display("[TB] asynchronous reset mid-grant");
    applyStimulus(4'b0100, 1'b0);
    nextCycle();
    checkOutput("pre_reset_grant", 1'b1, 2'd2, 1'b0);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", 1'b0, 2'd0, 1'b0);
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(4'b1001, 1'b0);
    nextCycle();
    checkOutput("post_reset_grant", 1'b1, 2'd0, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    nextCycle();
    nextCycle();

    $display("[TB] timeout disabled, long hold");
    pulseReset();
    applyStimulus(4'b0001, 1'b0);
    nextCycle();
    eHigh  = 0;
    tmoCnt = 0;
    for (int i = 0; i < 300; i++) begin
      nextCycle();
      if (e1 === 1'b1) eHigh++;
      if (t1 !== 1'b0) tmoCnt++;
    end
    checkValue("notimeout_e_cycles", eHigh, 300);
    checkValue("notimeout_tmo_pulses", tmoCnt, 0);
    applyStimulus(4'b0000, 1'b0);
    nextCycle();
    nextCycle();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 2500; i++) begin
      nextCycle();
      if (i % 800 == 799) begin
        pulseReset();
      end
      if ($urandom_range(0, 19) == 0) begin
        req = 4'($urandom_range(0, 15));
      end
      done = ($urandom_range(0, 29) == 0);
    end
    applyStimulus(4'b0000, 1'b0);
    nextCycle();
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
